fifo_drain: RTL and testbench
=============================

# fifo_drain

Read-side drain stage placed directly downstream of the 16-entry `fifo`. It watches the FIFO fill level, batches reads until a threshold or an explicit flush, and pops words with `fifo_ren`. The FIFO returns read data one cycle after the read strobe, so the block holds those words in a 2-entry skid buffer and presents them on a registered valid/ready stream. It never reads an empty FIFO, so the FIFO's read-while-empty skip path is never exercised from this side.

## Interface
- `DATA_W`, 8: data width; must equal FIFO `wdata`/`rdata` width.
- `COUNT_W`, 4: width of the FIFO count.
- `THRESH`, 8: fill level that starts a drain burst; legal range 1..15.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `drain_en`  in  1  global enable for issuing reads.
- `flush`  in  1  start draining regardless of `THRESH`; level-sensitive.
- `fifo_count`  in  `COUNT_W`  FIFO `count` output.
- `fifo_empty`  in  1  FIFO `empty` output.
- `fifo_ren`  out  1  FIFO read strobe.
- `fifo_rdata`  in  `DATA_W`  FIFO read data; valid the cycle after `fifo_ren`.
- `out_valid`  out  1  stream word valid; registered.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  `DATA_W`  stream word; head of skid buffer.
- `busy`  out  1  high in DRAIN or while any word is in flight or buffered.
- `xfer_count`  out  16  accepted-word counter; see Configuration.

## Operation
- Internal state: FSM `{IDLE, DRAIN}`, `inflight` (0..1), buffer occupancy `occ` (0..2), 2-entry FIFO-ordered buffer.
- `pop = out_valid && out_ready`.
- IDLE -> DRAIN when `drain_en && (fifo_count >= THRESH || flush)`.
- DRAIN -> IDLE when `!drain_en`, or when `fifo_empty` and `fifo_ren` is low in the same cycle.
- `fifo_ren = (state==DRAIN) && drain_en && !fifo_empty && (occ + inflight - pop) < 2`. It is combinational from these inputs.
- `inflight` is set in the cycle after `fifo_ren`. In that cycle `fifo_rdata` is written into the buffer tail.
- Buffered words continue to drain in either state; IDLE only stops new reads.
- Simultaneous capture and pop: `occ` is unchanged, the head advances, and the new word goes to the tail. The buffer never overflows. `occ + inflight <= 2` always holds.
- `out_valid = (occ != 0)`. `out_data` holds the head and stays stable while `out_valid && !out_ready`.
- Word order on the stream equals FIFO read order; no words are dropped or duplicated.
- `busy = (state==DRAIN) || inflight || occ != 0`.

## Timing
- Reset values: state IDLE, `occ` 0, `inflight` 0, `fifo_ren` 0, `out_valid` 0, `out_data` 0, `busy` 0, `xfer_count` 0.
- `rst` mid-operation discards buffered and in-flight words immediately. A FIFO read issued in the cycle before reset is lost.
- The start condition is true in cycle t. State is DRAIN in t+1, and the first `fifo_ren` is possible in t+1.
- `fifo_ren` in cycle t gives `out_valid` high in cycle t+2.
- With `out_ready` held high and the FIFO non-empty, `fifo_ren` is high every cycle: 1 word/cycle sustained.
- With `out_ready` low, at most 2 reads issue before `fifo_ren` stops. It resumes in the same cycle that a pop frees a slot.
- At FIFO count 1: one read issues, `fifo_empty` rises the next cycle, no further read issues, and the FSM returns to IDLE.
- A concurrent FIFO write at count 1 keeps `fifo_empty` low, and draining continues.

## Configuration
- `FIFO_DRAIN_XFER_COUNT_EN` defined:
  - `xfer_count` is a 16-bit register that increments on every `pop`.
  - It wraps 0xFFFF -> 0x0000 and clears on `rst`.
- Not defined: `xfer_count` is tied to 0 and no counter logic is built.

## Test plan
- Threshold start: `THRESH`=8, `drain_en`=1, `out_ready`=1; FIFO filled to 7, then 8.
  - No `fifo_ren` at count 7.
  - At count 8: 8 consecutive `fifo_ren` cycles, 8 stream words in write order, then IDLE with `busy`=0.
- Backpressure: `out_ready`=0 with FIFO count 10 and flush.
  - Exactly 2 reads, then `fifo_ren` stays low, `out_data` stays stable, and `out_valid`=1.
  - Release `out_ready`: the remaining 8 words arrive in order at 1 word/cycle.
- Empty boundary: count 1 with flush.
  - One `fifo_ren`, never `fifo_ren` while `fifo_empty`=1, one output word, FSM back to IDLE.
- Mid-burst disable: deassert `drain_en` after 3 reads of 10.
  - `fifo_ren` drops the same cycle and the buffered/in-flight words are still delivered.
  - Re-enable with flush: the remaining 7 words arrive in order.
- Reset mid-burst: assert `rst` with `occ`=2.
  - All outputs return to reset values asynchronously.
  - After release, no stale word appears.
  - With `FIFO_DRAIN_XFER_COUNT_EN`, `xfer_count` reads 0, then counts exactly the post-reset handshakes.

Source files
------------

// File: rtl/fifo_drain.sv
// ---------------------------------------------------------------------------
// fifo_drain
//
// Read-side drain stage that sits directly behind a 16-entry FIFO. It waits
// until the FIFO fill level reaches THRESH (or an explicit flush is asserted),
// then pops words with fifo_ren. The FIFO returns data one cycle after the
// strobe, so the captured words are parked in a 2-entry skid buffer and
// presented on a valid/ready stream. Reads are only issued when a buffer slot
// is guaranteed to be free by the time the data arrives, so the buffer can
// never overflow. The FIFO is never read while it reports empty.
//
// Optional feature macro: FIFO_DRAIN_XFER_COUNT_EN
//   defined     : xfer_count is a 16-bit wrapping count of accepted words
//   not defined : xfer_count is tied to zero and no counter is built
//
// Parameters
//   DATA_W   data width, matches the FIFO wdata/rdata width
//   COUNT_W  width of the FIFO count output
//   THRESH   fill level that starts a drain burst (1..15)
//
// Ports
//   clk         in   single clock, rising edge
//   rst         in   asynchronous active-high reset
//   drain_en    in   global enable for issuing reads
//   flush       in   start draining regardless of THRESH (level-sensitive)
//   fifo_count  in   FIFO fill level
//   fifo_empty  in   FIFO empty flag
//   fifo_ren    out  FIFO read strobe (combinational)
//   fifo_rdata  in   FIFO read data, valid the cycle after fifo_ren
//   out_valid   out  stream word valid
//   out_ready   in   downstream accept
//   out_data    out  stream word (head of the skid buffer)
//   busy        out  draining, or a word is in flight or buffered
//   xfer_count  out  accepted-word counter (see macro above)
// ---------------------------------------------------------------------------
module fifo_drain #(
   parameter int DATA_W  = 8,
   parameter int COUNT_W = 4,
   parameter int THRESH  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               drain_en,
   input  logic               flush,
   input  logic [COUNT_W-1:0] fifo_count,
   input  logic               fifo_empty,
   output logic               fifo_ren,
   input  logic [DATA_W-1:0]  fifo_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic               busy,
   output logic [15:0]        xfer_count
);

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              inflight;
   logic [1:0]        occ;
   logic [DATA_W-1:0] buf_head;
   logic [DATA_W-1:0] buf_tail;
   logic              pop;
   logic [2:0]        slots_used;
   logic              start;

   // Slots still committed after this cycle: words already buffered plus the
   // word on its way back from the FIFO, minus the one leaving this cycle.
   // A new read is only allowed while that leaves room for one more word,
   // which is what keeps occ + inflight from ever exceeding 2.
   always_comb begin
      pop        = (occ != 2'd0) && out_ready;
      slots_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
      start      = drain_en && ((fifo_count >= COUNT_W'(THRESH)) || flush);
      fifo_ren   = (state == DRAIN) && drain_en && !fifo_empty && (slots_used < 3'd2);
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (!drain_en || (fifo_empty && !fifo_ren)) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM state and the one-cycle read-latency tracker. inflight marks the
   // cycle in which fifo_rdata carries the word requested last cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         inflight <= 1'b0;
      end else begin
         state    <= state_next;
         inflight <= fifo_ren;
      end
   end

   // Two-entry skid buffer kept in FIFO order: buf_head is always the oldest
   // word. A capture with occ == 2 cannot happen without a simultaneous pop,
   // because the read that produced it was only issued when a slot was free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ      <= 2'd0;
         buf_head <= '0;
         buf_tail <= '0;
      end else begin
         case ({inflight, pop})
            2'b11: begin
               if (occ == 2'd2) begin
                  buf_head <= buf_tail;
                  buf_tail <= fifo_rdata;
               end else begin
                  buf_head <= fifo_rdata;
               end
            end
            2'b10: begin
               if (occ == 2'd0) begin
                  buf_head <= fifo_rdata;
               end else begin
                  buf_tail <= fifo_rdata;
               end
               occ <= occ + 2'd1;
            end
            2'b01: begin
               buf_head <= buf_tail;
               occ      <= occ - 2'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign out_valid = (occ != 2'd0);
   assign out_data  = buf_head;
   assign busy      = (state == DRAIN) || inflight || (occ != 2'd0);

`ifdef FIFO_DRAIN_XFER_COUNT_EN
   // Free-running count of accepted words; wraps naturally at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xfer_count <= 16'd0;
      end else if (pop) begin
         xfer_count <= xfer_count + 16'd1;
      end
   end
`else
   assign xfer_count = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// ---------------------------------------------------------------------------
// tb_fifo_drain
//
// Self-checking bench for fifo_drain. A small behavioural 16-entry FIFO feeds
// the DUT. Every word written into the FIFO is pushed onto a scoreboard queue;
// every accepted stream word is compared against the next queue entry. The
// per-cycle monitor also counts reads, accepted words and burst lengths, and
// checks that out_data holds while stalled and that no read hits an empty
// FIFO. Honours FIFO_DRAIN_XFER_COUNT_EN for the xfer_count expectations.
// ---------------------------------------------------------------------------
module tb_fifo_drain;

   localparam int DATA_W  = 8;
   localparam int COUNT_W = 4;
   localparam int THRESH  = 8;

   logic               clk;
   logic               rst;
   logic               drain_en;
   logic               flush;
   logic [COUNT_W-1:0] fifo_count;
   logic               fifo_empty;
   logic               fifo_ren;
   logic [DATA_W-1:0]  fifo_rdata;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  out_data;
   logic               busy;
   logic [15:0]        xfer_count;

   logic               fifo_wen;
   logic [DATA_W-1:0]  fifo_wdata;

   fifo_drain #(
      .DATA_W  (DATA_W),
      .COUNT_W (COUNT_W),
      .THRESH  (THRESH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .drain_en   (drain_en),
      .flush      (flush),
      .fifo_count (fifo_count),
      .fifo_empty (fifo_empty),
      .fifo_ren   (fifo_ren),
      .fifo_rdata (fifo_rdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy),
      .xfer_count (xfer_count)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural upstream FIFO: registered read data one cycle after fifo_ren,
   // cleared by the same reset as the DUT.
   logic [DATA_W-1:0] fifo_mem [16];
   logic [3:0]        wr_ptr;
   logic [3:0]        rd_ptr;
   logic [4:0]        fill;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= 4'd0;
         rd_ptr     <= 4'd0;
         fill       <= 5'd0;
         fifo_rdata <= '0;
      end else begin
         if (fifo_wen) begin
            fifo_mem[wr_ptr] <= fifo_wdata;
            wr_ptr           <= wr_ptr + 4'd1;
         end
         if (fifo_ren) begin
            fifo_rdata <= fifo_mem[rd_ptr];
            rd_ptr     <= rd_ptr + 4'd1;
         end
         fill <= fill + {4'd0, fifo_wen} - {4'd0, fifo_ren};
      end
   end

   assign fifo_count = fill[3:0];
   assign fifo_empty = (fill == 5'd0);

   // Scoreboard and statistics.
   logic [DATA_W-1:0] exp_q [$];
   int                exp_rd;
   int                n_checks;
   int                n_pass;
   int                ren_cnt;
   int                pop_cnt;
   int                ren_run;
   int                ren_max;
   int                pop_run;
   int                pop_max;
   logic              stall_prev;
   logic [DATA_W-1:0] stall_data;
   int                rb;
   int                pb;

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual === expected) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic logic [31:0] expXfer();
`ifdef FIFO_DRAIN_XFER_COUNT_EN
      return {16'd0, pop_cnt[15:0]};
`else
      return 32'd0;
`endif
   endfunction

   // Per-cycle monitor, called at the falling edge.
   task automatic sampleCycle();
      if (rst) begin
         exp_rd     = exp_q.size();
         pop_cnt    = 0;
         ren_run    = 0;
         pop_run    = 0;
         stall_prev = 1'b0;
      end else begin
         if (fifo_ren) begin
            ren_cnt++;
            ren_run++;
            if (ren_run > ren_max) ren_max = ren_run;
            checkOutput("ren_while_empty", {31'd0, fifo_empty}, 32'd0);
         end else begin
            ren_run = 0;
         end
         if (stall_prev) begin
            checkOutput("stall_data", {24'd0, out_data}, {24'd0, stall_data});
            checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
         end
         if (out_valid && out_ready) begin
            pop_cnt++;
            pop_run++;
            if (pop_run > pop_max) pop_max = pop_run;
            if (exp_rd < exp_q.size()) begin
               checkOutput("word_order", {24'd0, out_data}, {24'd0, exp_q[exp_rd]});
            end else begin
               checkOutput("extra_word", exp_rd + 1, exp_q.size());
            end
            exp_rd++;
         end else begin
            pop_run = 0;
         end
         stall_prev = out_valid && !out_ready;
         stall_data = out_data;
      end
   endtask

   // One clock cycle: sample at the falling edge, return just after the
   // next rising edge so new stimulus never races the active edge.
   task automatic tick();
      @(negedge clk);
      sampleCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic de, input logic fl, input logic rdy);
      drain_en  = de;
      flush     = fl;
      out_ready = rdy;
   endtask

   // Write one word into the upstream FIFO and record it as expected output.
   task automatic pushWord(input logic [DATA_W-1:0] d);
      fifo_wen   = 1'b1;
      fifo_wdata = d;
      exp_q.push_back(d);
      tick();
      fifo_wen   = 1'b0;
   endtask

   task automatic fillWords(input int n, input logic [DATA_W-1:0] base);
      for (int i = 0; i < n; i++) begin
         pushWord(base + DATA_W'(i));
      end
   endtask

   task automatic waitIdle(input int max_cycles);
      repeat (2) tick();
      for (int i = 0; i < max_cycles; i++) begin
         if (!busy) break;
         tick();
      end
      checkOutput("idle_reached", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      exp_rd     = 0;
      ren_cnt    = 0;
      pop_cnt    = 0;
      ren_run    = 0;
      ren_max    = 0;
      pop_run    = 0;
      pop_max    = 0;
      stall_prev = 1'b0;
      stall_data = '0;
      fifo_wen   = 1'b0;
      fifo_wdata = '0;
      rst        = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Reset values.
      #12;
      checkOutput("rst_ren", {31'd0, fifo_ren}, 32'd0);
      checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_data", {24'd0, out_data}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_xfer", {16'd0, xfer_count}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();

      // Threshold start: nothing at 7, an 8-read burst at 8.
      $display("[TB] threshold start");
      applyStimulus(1'b1, 1'b0, 1'b1);
      rb = ren_cnt;
      pb = pop_cnt;
      fillWords(7, 8'h10);
      repeat (4) tick();
      checkOutput("no_ren_at_7", ren_cnt - rb, 0);
      checkOutput("idle_at_7", {31'd0, busy}, 32'd0);
      ren_max = 0;
      pushWord(8'h17);
      waitIdle(40);
      checkOutput("thresh_reads", ren_cnt - rb, 8);
      checkOutput("thresh_burst", ren_max, 8);
      checkOutput("thresh_words", pop_cnt - pb, 8);
      checkOutput("thresh_drained", exp_rd, exp_q.size());
      checkOutput("thresh_xfer", {16'd0, xfer_count}, expXfer());

      // Backpressure: two reads then stall, then 1 word/cycle on release.
      $display("[TB] backpressure");
      applyStimulus(1'b0, 1'b0, 1'b0);
      fillWords(10, 8'h20);
      rb = ren_cnt;
      pb = pop_cnt;
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (6) tick();
      checkOutput("bp_reads", ren_cnt - rb, 2);
      checkOutput("bp_ren_low", {31'd0, fifo_ren}, 32'd0);
      checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_head", {24'd0, out_data}, {24'd0, exp_q[exp_rd]});
      pop_max = 0;
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitIdle(40);
      checkOutput("bp_total_reads", ren_cnt - rb, 10);
      checkOutput("bp_words", pop_cnt - pb, 10);
      checkOutput("bp_rate", pop_max, 10);
      checkOutput("bp_drained", exp_rd, exp_q.size());

      // Empty boundary: a single word with flush.
      $display("[TB] empty boundary");
      rb = ren_cnt;
      pb = pop_cnt;
      applyStimulus(1'b1, 1'b1, 1'b1);
      pushWord(8'h5A);
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitIdle(20);
      repeat (3) tick();
      checkOutput("one_read", ren_cnt - rb, 1);
      checkOutput("one_word", pop_cnt - pb, 1);
      checkOutput("one_idle", {31'd0, busy}, 32'd0);

      // Mid-burst disable after three reads, then resume with flush.
      $display("[TB] mid-burst disable");
      applyStimulus(1'b0, 1'b0, 1'b1);
      fillWords(10, 8'h40);
      rb = ren_cnt;
      pb = pop_cnt;
      applyStimulus(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 40 && (ren_cnt - rb) < 3; i++) begin
         tick();
         flush = 1'b0;
      end
      checkOutput("dis_three_reads", ren_cnt - rb, 3);
      applyStimulus(1'b0, 1'b0, 1'b1);
      #1;
      checkOutput("dis_ren_drop", {31'd0, fifo_ren}, 32'd0);
      waitIdle(20);
      checkOutput("dis_reads_held", ren_cnt - rb, 3);
      checkOutput("dis_words", pop_cnt - pb, 3);
      applyStimulus(1'b1, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitIdle(40);
      checkOutput("dis_total_reads", ren_cnt - rb, 10);
      checkOutput("dis_total_words", pop_cnt - pb, 10);
      checkOutput("dis_drained", exp_rd, exp_q.size());
      checkOutput("pre_rst_xfer", {16'd0, xfer_count}, expXfer());

      // Reset with the skid buffer full.
      $display("[TB] reset mid-burst");
      applyStimulus(1'b0, 1'b0, 1'b0);
      fillWords(10, 8'h60);
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (5) tick();
      checkOutput("full_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("full_busy", {31'd0, busy}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_ren", {31'd0, fifo_ren}, 32'd0);
      checkOutput("arst_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("arst_data", {24'd0, out_data}, 32'd0);
      checkOutput("arst_busy", {31'd0, busy}, 32'd0);
      checkOutput("arst_xfer", {16'd0, xfer_count}, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (5) tick();
      checkOutput("no_stale_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("no_stale_words", exp_rd, exp_q.size());
      checkOutput("post_rst_xfer0", {16'd0, xfer_count}, expXfer());
      pb = pop_cnt;
      applyStimulus(1'b1, 1'b1, 1'b1);
      pushWord(8'hA1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      pushWord(8'hA2);
      pushWord(8'hA3);
      waitIdle(30);
      checkOutput("post_rst_words", pop_cnt - pb, 3);
      checkOutput("post_rst_drained", exp_rd, exp_q.size());
      checkOutput("post_rst_xfer", {16'd0, xfer_count}, expXfer());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
